// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding, default widths and one-hot helper for the data-memory arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  localparam int NUM_REQ_DEF   = 3;
  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int MEM_DEPTH_DEF = 32;
  function automatic logic [7:0] idx_to_onehot(input logic [2:0] idx);
    return 8'd1 << idx;
  endfunction
endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority picker, first set request at or above ptr with wrap
module rr_pick import dmem_arb_pkg::*; #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx,
  output logic          any
);
  always_comb begin
    int j;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        grant_idx = IW'(j);
        any       = 1'b1;
      end
    end
    grant_onehot = any ? N'(idx_to_onehot(3'(grant_idx))) : '0;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter serialising requester loads/stores onto a single-port data memory
module dmem_arbiter import dmem_arb_pkg::*; #(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      resp_err,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);
  localparam int IW = $clog2(NUM_REQ);
  state_t              r_state, w_next;
  logic [IW-1:0]       r_ptr, r_idx, w_gidx;
  logic                r_we, r_err, w_any, w_in_range;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_rdata;
  logic [NUM_REQ-1:0]  w_goh;
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req          (req_valid),
    .ptr          (r_ptr),
    .grant_onehot (w_goh),
    .grant_idx    (w_gidx),
    .any          (w_any)
  );
  always_comb begin
    w_in_range = r_addr < ADDR_W'(MEM_DEPTH);
    w_next     = (r_state == IDLE) ? (w_any && rst ? ACCESS : IDLE) :
                 (r_state == ACCESS) ? RESP : IDLE;
    req_ready  = (r_state == IDLE && rst) ? w_goh : '0;
    resp_valid = (r_state == RESP) ? NUM_REQ'(idx_to_onehot(3'(r_idx))) : '0;
    mem_we     = (r_state == ACCESS) && r_we && w_in_range && rst;
    mem_addr   = r_addr;
    mem_wdata  = r_wdata;
    resp_rdata = r_rdata;
    resp_err   = r_err;
  end
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr   <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_idx   <= w_gidx;
        r_we    <= req_we[w_gidx];
        r_addr  <= req_addr[w_gidx*ADDR_W +: ADDR_W];
        r_wdata <= req_wdata[w_gidx*DATA_W +: DATA_W];
      end
      if (r_state == ACCESS) begin
        r_rdata <= (!r_we && w_in_range) ? mem_rdata : '0;
        r_err   <= !w_in_range;
      end
      if (r_state == RESP) r_ptr <= (r_idx == IW'(NUM_REQ - 1)) ? '0 : IW'(r_idx + 1'b1);
    end
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Round-robin arbiter sharing the single-port 32-bit data memory among NUM_REQ requesters, e.g. the three TMR core replicas or a core plus a debug/loader port. Each requester issues one load or store through a valid/ready handshake. The block serialises the accesses, drives the memory's write-enable, address and write-data inputs, and returns read data or a range error to the winner. It sits between the requesters' memory stages and the data memory instance.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ADDR_W, 32, word-address width
DATA_W, 32, data width
MEM_DEPTH, 32, number of valid memory words; addresses >= MEM_DEPTH are out of range

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-low
req_valid  input  NUM_REQ  per-requester request valid
req_we  input  NUM_REQ  per-requester store (1) or load (0)
req_addr  input  NUM_REQ*ADDR_W  flattened word addresses; requester i uses slice i
req_wdata  input  NUM_REQ*DATA_W  flattened store data
req_ready  output  NUM_REQ  one-hot accept strobe
resp_valid  output  NUM_REQ  one-hot response strobe
resp_rdata  output  DATA_W  load data, valid with resp_valid
resp_err  output  1  out-of-range flag, valid with resp_valid
mem_we  output  1  to memory WE
mem_addr  output  ADDR_W  to memory A
mem_wdata  output  DATA_W  to memory WD
mem_rdata  input  DATA_W  from memory RD (combinational read)

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-low: rst==0 at a rising edge loads reset state.
  - Reset state:
    - FSM = IDLE
    - rr pointer = 0
    - latched command = 0
    - req_ready = 0, resp_valid = 0
    - resp_rdata = 0, resp_err = 0
    - mem_addr = 0, mem_wdata = 0
  - mem_we is forced to 0 combinationally whenever rst==0, so no store can land on the reset edge, including reset asserted mid-ACCESS.
- FSM IDLE -> ACCESS -> RESP -> IDLE. Throughput is one transaction per 3 cycles; response latency is 2 cycles after acceptance.
- IDLE:
  - Winner = first requester with req_valid set, searching from the rr pointer upward with wrap (NUM_REQ-1 wraps to 0).
  - req_ready is combinational and one-hot on the winner; it is 0 if no request is pending.
  - At the edge, the winner's index, we, addr and wdata are latched, and the FSM moves to ACCESS.
  - Requesters hold valid and payload stable until they see ready; a valid dropped before ready is legal and means no access.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latched command.
  - mem_we = latched_we AND in_range AND rst, where in_range = latched_addr < MEM_DEPTH.
  - At the edge:
    - resp_rdata <= (load and in_range) ? mem_rdata : 0
    - resp_err <= !in_range
    - The FSM moves to RESP.
- RESP:
  - resp_valid is one-hot on the latched winner for exactly one cycle.
  - rr pointer <= (winner+1) mod NUM_REQ.
  - The FSM returns to IDLE.
  - resp_rdata and resp_err hold their values until the next ACCESS edge.
  - mem_we = 0.
- Outside ACCESS, mem_we is 0; mem_addr and mem_wdata hold the last latched values.
- Stores complete at the ACCESS edge. A load following a store is serialised, so it always sees the stored data.
- An out-of-range store writes nothing and returns resp_err=1 and rdata=0.
- Simultaneous requests: exactly one requester is granted per IDLE cycle. Any requester with valid held is granted within NUM_REQ transactions (no starvation).
- A requester may assert a new valid in the same cycle its resp_valid is high; that request is arbitrated in the following IDLE cycle.

Decomposition:
- Package dmem_arb_pkg holds:
  - FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
  - default-width localparams
  - a function idx_to_onehot
- Sub-module rr_pick:
  - Purely combinational rotate-priority picker.
  - Inputs: req vector, pointer.
  - Outputs: grant_onehot, grant_idx, any.
- The top module holds the FSM, command latch, response registers and pointer.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req_valid=3'b111 -> req_ready=0, resp_valid=0, mem_we=0, resp_rdata=0 throughout.
- Single store then load: requester 1 stores 32'hDEADBEEF to addr 5, then loads addr 5 -> mem_we high for exactly one cycle, 1 cycle after req_ready; resp_valid=3'b010 2 cycles after each accept; load returns 32'hDEADBEEF with resp_err=0.
- Contention: all three assert loads together from reset -> grants in order 0,1,2, with accepts spaced 3 cycles apart; with all held continuously, the next round repeats 0,1,2.
- Fairness after wrap: pointer at 2 with requesters 0 and 2 valid -> 2 is granted first, then 0.
- Out of range: store to addr 32 (MEM_DEPTH=32) -> mem_we stays 0, resp_err=1, resp_rdata=0, memory word 0 unchanged.
- Reset mid-operation: drive rst=0 during the ACCESS cycle of a store to addr 3 -> no write to addr 3, no resp_valid, FSM back in IDLE with pointer 0.
